cache_fsm: RTL

Controller FSM for the direct-mapped, write-back, write-allocate data/instruction cache that serves the multicycle core's main control FSM. It accepts the core's cache-start strobe, checks hit/dirty status from the tag array, and returns a stall signal that holds the main FSM in its fetch/memory state. On a miss it writes back a dirty victim line and refills the line from main memory word-by-word over a ready handshake.

---
 rtl/cache_fsm.sv | 108 ++++++++++
 1 files changed

// File: rtl/cache_fsm.sv
// Cache controller FSM: hit/miss detection, dirty write-back burst, refill burst and tag update.
// Bursts run word-by-word over a ready handshake; o_stall holds the core until the access hits.
module cache_fsm #(
    parameter int unsigned BLOCK_WORDS = 16,
    parameter int unsigned CNT_W       = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_start_cache,
    input  logic             i_write,
    input  logic             i_hit,
    input  logic             i_dirty,
    input  logic             i_mem_ready,
    output logic             o_stall,
    output logic             o_mem_wr_req,
    output logic             o_mem_rd_req,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic             o_refill_we,
    output logic             o_tag_we,
    output logic             o_dirty_set
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITE_BACK  = 2'd1,
        ALLOCATE    = 2'd2,
        REFILL_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST_WORD);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start_cache && !i_hit) begin
                        r_cnt   <= '0;
                        r_state <= i_dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (i_mem_ready) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= ALLOCATE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ALLOCATE: begin
                    if (i_mem_ready) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= REFILL_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                REFILL_DONE: r_state <= IDLE;
                default:     r_state <= IDLE;
            endcase
        end
    end

    // IDLE outputs are combinational so a hit completes with zero latency.
    always_comb begin
        o_stall      = 1'b0;
        o_mem_wr_req = 1'b0;
        o_mem_rd_req = 1'b0;
        o_refill_we  = 1'b0;
        o_tag_we     = 1'b0;
        o_dirty_set  = 1'b0;
        case (r_state)
            IDLE: begin
                o_stall     = i_start_cache & ~i_hit;
                o_dirty_set = i_start_cache & i_hit & i_write;
            end
            WRITE_BACK: begin
                o_stall      = 1'b1;
                o_mem_wr_req = 1'b1;
            end
            ALLOCATE: begin
                o_stall      = 1'b1;
                o_mem_rd_req = 1'b1;
                o_refill_we  = i_mem_ready;
            end
            REFILL_DONE: begin
                o_stall  = 1'b1;
                o_tag_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_word_cnt = r_cnt;

endmodule
